// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised monitor UART.
// Holds the FSM state type, the divisor floor, and the parity/majority helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned MIN_DIV = 4;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic majority5(input logic [4:0] taps);
    logic [2:0] ones;
    ones = 3'(taps[0]) + 3'(taps[1]) + 3'(taps[2]) + 3'(taps[3]) + 3'(taps[4]);
    return ones >= 3'd3;
  endfunction

endpackage

// File: rtl/uart_fifo_p.sv
// Byte FIFO with async-read head, occupancy counter and one-cycle overrun/underrun pulses.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
module uart_fifo_p #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          rd,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          underrun
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = count[AW];
  assign empty = (count == '0);
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | rd);
  assign rdata = empty ? 8'h00 : mem[rptr];

  // NOTE: storage has no reset; the occupancy counter alone decides validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun  <= wr & full & ~rd;
      underrun <= rd & empty;
    end
  end

endmodule

// File: rtl/uart_core_p.sv
// Monitor UART: run-time baud divisor, optional parity, rx/tx FIFOs and error pulses.
// RX and TX FSMs latch their configuration per frame so mid-frame changes are harmless.
module uart_core_p
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic               parity_en,
  input  logic               parity_odd,
  input  logic               rx,
  output logic               tx,
  input  logic               rx_rden,
  output logic [7:0]         rx_rdata,
  output logic               rx_dvalid,
  output logic               rx_full,
  output logic [FIFO_AW:0]   rx_count,
  output logic               rx_overrun,
  output logic               rx_underrun,
  output logic               rx_frame_err,
  output logic               rx_parity_err,
  input  logic [7:0]         tx_wdata,
  input  logic               tx_wten,
  output logic               tx_full,
  output logic               tx_busy,
  output logic               tx_overrun
);

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

  // ---------------- RX front end ----------------
  logic       rx_meta, rx_sync, rx_bit, rx_bit_q, rx_fall;
  logic [4:0] rx_taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_taps  <= '1;
      rx_bit_q <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_taps  <= {rx_taps[3:0], rx_sync};
      rx_bit_q <= rx_bit;
    end
  end

  assign rx_bit  = majority5(rx_taps);
  assign rx_fall = rx_bit_q & ~rx_bit;

  // ---------------- RX FSM ----------------
  uart_state_e      rx_state;
  logic [DIV_W-1:0] rx_cnt, rx_div;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             rx_par, rx_par_en, rx_par_odd, rx_push, rx_empty, rx_tick;

  assign rx_tick = (rx_cnt == DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= ST_IDLE;
      rx_cnt        <= '0;
      rx_div        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      rx_par_en     <= 1'b0;
      rx_par_odd    <= 1'b0;
      rx_push       <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_push       <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      if (rx_state != ST_IDLE) rx_cnt <= rx_tick ? rx_div : rx_cnt - 1'b1;
      unique case (rx_state)
        ST_IDLE: if (rx_fall) begin
          rx_state   <= ST_START;
          rx_div     <= div_eff;
          rx_cnt     <= div_eff >> 1;
          rx_par_en  <= parity_en;
          rx_par_odd <= parity_odd;
        end
        ST_START: if (rx_tick) begin
          rx_state <= rx_bit ? ST_IDLE : ST_DATA;
          rx_idx   <= '0;
        end
        ST_DATA: if (rx_tick) begin
          rx_shift <= {rx_bit, rx_shift[7:1]};
          rx_idx   <= rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_state <= rx_par_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: if (rx_tick) begin
          rx_par   <= rx_bit;
          rx_state <= ST_STOP;
        end
        ST_STOP: if (rx_tick) begin
          rx_state <= ST_IDLE;
          if (!rx_bit) rx_frame_err <= 1'b1;
          else if (rx_par_en && (rx_par != parity_bit(rx_shift, rx_par_odd))) rx_parity_err <= 1'b1;
          else rx_push <= 1'b1;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Overrun on a full FIFO is detected inside the FIFO when the push lands.
  uart_fifo_p #(.AW(FIFO_AW)) u_rx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (rx_push),
    .wdata    (rx_shift),
    .rd       (rx_rden),
    .rdata    (rx_rdata),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count),
    .overrun  (rx_overrun),
    .underrun (rx_underrun)
  );

  assign rx_dvalid = ~rx_empty;

  // ---------------- TX path ----------------
  uart_state_e      tx_state;
  logic [DIV_W-1:0] tx_cnt, tx_div;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift, tx_head;
  logic             tx_par, tx_par_en, tx_empty, tx_tick, tx_start, tx_underrun;
  logic [FIFO_AW:0] tx_count;
  logic             unused_tx;

  assign tx_tick  = (tx_cnt == DIV_W'(1));
  // A new frame starts from IDLE or straight out of the last STOP cycle, so there is no gap.
  assign tx_start = ~tx_empty & ((tx_state == ST_IDLE) | ((tx_state == ST_STOP) & tx_tick));

  uart_fifo_p #(.AW(FIFO_AW)) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (tx_wten),
    .wdata    (tx_wdata),
    .rd       (tx_start),
    .rdata    (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count),
    .overrun  (tx_overrun),
    .underrun (tx_underrun)
  );

  assign unused_tx = ^{tx_underrun, tx_count};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_div    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_par_en <= 1'b0;
      tx        <= 1'b1;
    end else begin
      if (tx_state != ST_IDLE) tx_cnt <= tx_tick ? tx_div : tx_cnt - 1'b1;
      if (tx_start) begin
        tx_state  <= ST_START;
        tx_shift  <= tx_head;
        tx_div    <= div_eff;
        tx_cnt    <= div_eff;
        tx_par_en <= parity_en;
        tx_par    <= parity_bit(tx_head, parity_odd);
        tx        <= 1'b0;
      end else begin
        unique case (tx_state)
          ST_IDLE: tx <= 1'b1;
          ST_START: if (tx_tick) begin
            tx_state <= ST_DATA;
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
          end
          ST_DATA: if (tx_tick) begin
            if (tx_idx == 3'd7) begin
              tx_state <= tx_par_en ? ST_PARITY : ST_STOP;
              tx       <= tx_par_en ? tx_par : 1'b1;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
          ST_PARITY: if (tx_tick) begin
            tx_state <= ST_STOP;
            tx       <= 1'b1;
          end
          ST_STOP: if (tx_tick) begin
            tx_state <= ST_IDLE;
            tx       <= 1'b1;
          end
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_busy = (tx_state != ST_IDLE) | ~tx_empty;

endmodule

// File: tb/tb_uart_core_p.sv
// Scoreboard bench for uart_core_p: stimulus queues expected pulses, read bytes and tx frames;
// independent monitors pop and compare whenever the DUT presents them.
module tb_uart_core_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, rx, tx, rx_rden;
  logic [7:0]  rx_rdata, tx_wdata;
  logic        rx_dvalid, rx_full, rx_overrun, rx_underrun, rx_frame_err, rx_parity_err;
  logic [3:0]  rx_count;
  logic        tx_wten, tx_full, tx_busy, tx_overrun;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_FRAME, EV_PARITY, EV_RX_OVR, EV_RX_UND, EV_TX_OVR} ev_e;
  typedef struct {
    logic [10:0] bits;     // line level per bit slot, slot 0 = start bit
    int          nbits;
    int          div;
    logic        chained;  // starts the cycle after the previous frame's stop bit
    logic [7:0]  data;
  } tx_exp_t;

  ev_e        ev_q[$];
  logic [7:0] rd_q[$];
  tx_exp_t    tx_q[$];

  always #5 clk = ~clk;

  uart_core_p #(.FIFO_AW(3), .DIV_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_div      (baud_div),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .rx            (rx),
    .tx            (tx),
    .rx_rden       (rx_rden),
    .rx_rdata      (rx_rdata),
    .rx_dvalid     (rx_dvalid),
    .rx_full       (rx_full),
    .rx_count      (rx_count),
    .rx_overrun    (rx_overrun),
    .rx_underrun   (rx_underrun),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .tx_wdata      (tx_wdata),
    .tx_wten       (tx_wten),
    .tx_full       (tx_full),
    .tx_busy       (tx_busy),
    .tx_overrun    (tx_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_e seen, input string name);
    ev_e want;
    if (ev_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected pulse expected none", name);
    end else begin
      want = ev_q.pop_front();
      check(name, 32'(seen), 32'(want));
    end
  endtask

  // Error/status pulse monitor.
  initial forever begin
    @(negedge clk);
    if (rx_frame_err)  expect_ev(EV_FRAME,  "rx_frame_err");
    if (rx_parity_err) expect_ev(EV_PARITY, "rx_parity_err");
    if (rx_overrun)    expect_ev(EV_RX_OVR, "rx_overrun");
    if (rx_underrun)   expect_ev(EV_RX_UND, "rx_underrun");
    if (tx_overrun)    expect_ev(EV_TX_OVR, "tx_overrun");
  end

  // Read-data monitor: the head byte is compared on every pop the bench expects to succeed.
  initial forever begin
    @(negedge clk);
    if (rst_n && rx_rden && rd_q.size() > 0) begin
      check("rx_dvalid_on_read", 32'(rx_dvalid), 32'd1);
      check("rx_rdata", 32'(rx_rdata), 32'(rd_q.pop_front()));
    end
  end

  // TX line monitor: compares every clock of a frame, one check per frame.
  initial begin : tx_mon
    tx_exp_t f;
    bit active, bad, idle_chk;
    int cyc;
    active = 0; bad = 0; idle_chk = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active   = 0;
        idle_chk = 0;
      end else begin
        if (idle_chk) begin
          check("tx_busy_after_stop", 32'(tx_busy), 32'd0);
          check("tx_idle_level", 32'(tx), 32'd1);
          idle_chk = 0;
        end else if (!active && tx_q.size() > 0 && tx === 1'b0) begin
          f = tx_q.pop_front();
          active = 1; cyc = 0; bad = 0;
        end
        if (active) begin
          if (tx !== f.bits[cyc / f.div] || tx_busy !== 1'b1) bad = 1;
          cyc++;
          if (cyc == f.nbits * f.div) begin
            check($sformatf("tx_frame_%02h", f.data), 32'(bad), 32'd0);
            active = 0;
            if (tx_q.size() > 0 && tx_q[0].chained) begin
              f = tx_q.pop_front();
              active = 1; cyc = 0; bad = 0;
            end else if (tx_q.size() == 0) begin
              idle_chk = 1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one rx frame; slot 0 start, 1..8 data LSB first, optional parity, stop, then 2 idle bits.
  task automatic send_rx(input logic [7:0] d, input logic par_on, input logic par_val,
                         input logic stop_val, input int div);
    logic [10:0] bits;
    int n;
    if (par_on) begin bits = {stop_val, par_val, d, 1'b0}; n = 11; end
    else        begin bits = {1'b1, stop_val, d, 1'b0};    n = 10; end
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      tick(div);
    end
    rx = 1'b1;
    tick(2 * div);
  endtask

  task automatic rd_pop();
    rx_rden = 1'b1;
    tick(1);
    rx_rden = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] d);
    tx_wdata = d;
    tx_wten  = 1'b1;
    tick(1);
    tx_wten  = 1'b0;
  endtask

  initial begin
    tx_exp_t e;
    rx = 1'b1; rx_rden = 1'b0; tx_wten = 1'b0; tx_wdata = '0;
    baud_div = 16'd54; parity_en = 1'b0; parity_odd = 1'b0;
    tick(3);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_rx_count", 32'(rx_count), 32'd0);
    check("reset_rx_dvalid", 32'(rx_dvalid), 32'd0);
    check("reset_rx_rdata", 32'(rx_rdata), 32'd0);
    check("reset_tx_busy", 32'(tx_busy), 32'd0);
    check("reset_rx_full", 32'(rx_full), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // 8N1 at div 54.
    rd_q.push_back(8'h55);
    send_rx(8'h55, 1'b0, 1'b0, 1'b1, 54);
    check("rx55_count", 32'(rx_count), 32'd1);
    check("rx55_dvalid", 32'(rx_dvalid), 32'd1);
    check("rx55_rdata", 32'(rx_rdata), 32'h55);
    rd_pop();
    check("rx55_count_after_pop", 32'(rx_count), 32'd0);

    // Even parity at div 20: 0xA3 has four ones, so the correct parity bit is 0.
    baud_div = 16'd20; parity_en = 1'b1; parity_odd = 1'b0;
    ev_q.push_back(EV_PARITY);
    send_rx(8'hA3, 1'b1, 1'b1, 1'b1, 20);
    check("parity_err_discard", 32'(rx_count), 32'd0);
    rd_q.push_back(8'hA3);
    send_rx(8'hA3, 1'b1, 1'b0, 1'b1, 20);
    check("parity_ok_count", 32'(rx_count), 32'd1);
    rd_pop();

    // Stop bit 0, then a 2-clock glitch on the idle line.
    parity_en = 1'b0;
    ev_q.push_back(EV_FRAME);
    send_rx(8'h3C, 1'b0, 1'b0, 1'b0, 20);
    check("frame_err_discard", 32'(rx_count), 32'd0);
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(60);
    check("glitch_count", 32'(rx_count), 32'd0);
    check("rx_events_pending", 32'(ev_q.size()), 32'd0);

    // Fill the 8-deep rx FIFO and overflow it with a 9th byte.
    baud_div = 16'd16;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) rd_q.push_back(8'(i));
      else        ev_q.push_back(EV_RX_OVR);
      send_rx(8'(i), 1'b0, 1'b0, 1'b1, 16);
      if (i == 8) begin
        check("rx_full_after_8", 32'(rx_full), 32'd1);
        check("rx_count_after_8", 32'(rx_count), 32'd8);
      end
    end
    check("rx_count_after_ovr", 32'(rx_count), 32'd8);
    for (int i = 0; i < 8; i++) rd_pop();
    ev_q.push_back(EV_RX_UND);
    rd_pop();
    tick(2);
    check("rx_count_drained", 32'(rx_count), 32'd0);
    check("rx_dvalid_drained", 32'(rx_dvalid), 32'd0);

    // Back-to-back tx, div 10, odd parity: ^0x41=0 and ^0x0F=0, so both parity bits are 1.
    baud_div = 16'd10; parity_en = 1'b1; parity_odd = 1'b1;
    e = '{bits: 11'b11_01000001_0, nbits: 11, div: 10, chained: 1'b0, data: 8'h41};
    tx_q.push_back(e);
    e = '{bits: 11'b11_00001111_0, nbits: 11, div: 10, chained: 1'b1, data: 8'h0F};
    tx_q.push_back(e);
    tx_wdata = 8'h41; tx_wten = 1'b1;
    tick(1);
    tx_wdata = 8'h0F;
    tick(1);
    tx_wten = 1'b0;
    for (int i = 0; i < 400 && tx_busy; i++) @(negedge clk);
    check("tx_busy_timeout", 32'(tx_busy), 32'd0);
    tick(2);
    check("tx_frames_pending", 32'(tx_q.size()), 32'd0);

    // TX overrun: the first byte moves into the shifter, then eight fill the FIFO and the next drops.
    baud_div = 16'd6; parity_en = 1'b0;
    e = '{bits: 11'b0_1_11000011_0, nbits: 10, div: 6, chained: 1'b0, data: 8'hC3};
    tx_q.push_back(e);
    tx_push(8'hC3);
    tick(3);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) ev_q.push_back(EV_TX_OVR);
      tx_push(8'(8'h10 + i));
    end
    tick(1);
    check("tx_full_after_fill", 32'(tx_full), 32'd1);
    check("tx_busy_mid_frame", 32'(tx_busy), 32'd1);
    tick(3);
    rst_n = 1'b0;
    tx_q.delete();
    #1;
    check("tx_high_in_reset", 32'(tx), 32'd1);
    tick(2);
    check("tx_busy_in_reset", 32'(tx_busy), 32'd0);
    check("tx_full_in_reset", 32'(tx_full), 32'd0);
    rst_n = 1'b1;
    tick(5);
    check("tx_idle_after_reset", 32'(tx), 32'd1);
    check("tx_busy_after_reset", 32'(tx_busy), 32'd0);

    check("events_pending_end", 32'(ev_q.size()), 32'd0);
    check("reads_pending_end", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
